// File: rtl/enc_speed_meter.sv
// enc_speed_meter: quadrature encoder front end for one motor.
// Synchronises A/B/I, decodes 4x quadrature into a wrapping signed position,
// accumulates a saturating per-window speed, and flags stalls, index pulses
// and illegal A/B transitions. All outputs are registered.
module enc_speed_meter #(
  parameter int K_CNT_W     = 16,
  parameter int K_WIN_W     = 16,
  parameter int K_STALL_WIN = 4
) (
  input  logic                      i_clk,
  input  logic                      i_rst_n,
  input  logic                      i_enc_a,
  input  logic                      i_enc_b,
  input  logic                      i_enc_i,
  input  logic                      i_enc_pol,
  input  logic                      i_idx_clr_en,
  input  logic                      i_tick,
  input  logic [K_WIN_W-1:0]        i_window,
  input  logic                      i_clr,
  output logic signed [K_CNT_W-1:0] o_position,
  output logic signed [K_CNT_W-1:0] o_speed,
  output logic                      o_speed_valid,
  output logic                      o_dir,
  output logic                      o_stall,
  output logic                      o_index_seen,
  output logic                      o_err
);

  localparam logic [K_CNT_W-1:0] CNT_MAX = {1'b0, {(K_CNT_W-1){1'b1}}};
  localparam logic [K_CNT_W-1:0] CNT_MIN = {1'b1, {(K_CNT_W-1){1'b0}}};

  logic [1:0]         a_sync;
  logic [1:0]         b_sync;
  logic [1:0]         i_sync;
  logic [1:0]         prev_ab;
  logic               prev_i;

  logic [1:0]         cur_pair;
  logic [1:0]         prev_pair;
  logic [1:0]         phase_diff;
  logic               step_up;
  logic               step_dn;
  logic               step_bad;
  logic               idx_rise;

  logic [K_CNT_W-1:0] pos_q;
  logic [K_CNT_W-1:0] acc_q;
  logic [K_CNT_W-1:0] speed_q;
  logic [K_CNT_W:0]   step_ext;
  logic [K_CNT_W:0]   acc_sum;
  logic [K_CNT_W-1:0] acc_sat;

  logic [K_WIN_W-1:0] tick_cnt;
  logic               win_en;
  logic               win_end;

  logic [7:0]         stall_cnt;
  logic [7:0]         stall_next;

  // Gray-coded quadrature phase to a 0..3 binary phase index.
  function automatic logic [1:0] gray2bin(input logic [1:0] g);
    return {g[1], g[1] ^ g[0]};
  endfunction

  // Two-flop synchronisers on the asynchronous encoder pins.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      a_sync <= '0;
      b_sync <= '0;
      i_sync <= '0;
    end else begin
      a_sync <= {a_sync[0], i_enc_a};
      b_sync <= {b_sync[0], i_enc_b};
      i_sync <= {i_sync[0], i_enc_i};
    end
  end

  // Previous synchronised pin state; raw A/B kept so a polarity change never fakes a step.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      prev_ab <= '0;
      prev_i  <= 1'b0;
    end else begin
      prev_ab <= {a_sync[1], b_sync[1]};
      prev_i  <= i_sync[1];
    end
  end

  // Step decode: phase difference +1 forward, -1 reverse, 2 means both bits flipped.
  always_comb begin
    cur_pair   = i_enc_pol ? {b_sync[1], a_sync[1]} : {a_sync[1], b_sync[1]};
    prev_pair  = i_enc_pol ? {prev_ab[0], prev_ab[1]} : prev_ab;
    phase_diff = gray2bin(cur_pair) - gray2bin(prev_pair);
    step_up    = (phase_diff == 2'd1);
    step_dn    = (phase_diff == 2'd3);
    step_bad   = (phase_diff == 2'd2);
    idx_rise   = i_sync[1] & ~prev_i;
  end

  // Saturating accumulator add and window-end detection.
  always_comb begin
    step_ext = '0;
    if (step_up) begin
      step_ext = (K_CNT_W+1)'(1);
    end else if (step_dn) begin
      step_ext = '1;
    end
    acc_sum = {acc_q[K_CNT_W-1], acc_q} + step_ext;
    if (acc_sum[K_CNT_W] != acc_sum[K_CNT_W-1]) begin
      acc_sat = acc_sum[K_CNT_W] ? CNT_MIN : CNT_MAX;
    end else begin
      acc_sat = acc_sum[K_CNT_W-1:0];
    end
    win_en  = (i_window != '0);
    win_end = win_en && i_tick && (tick_cnt >= (i_window - K_WIN_W'(1)));
    if (acc_sat != '0) begin
      stall_next = '0;
    end else if (stall_cnt == 8'hFF) begin
      stall_next = stall_cnt;
    end else begin
      stall_next = stall_cnt + 8'd1;
    end
  end

  // Wrapping position counter; an index clear discards a coincident step.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      pos_q <= '0;
    end else if (i_clr) begin
      pos_q <= '0;
    end else if (idx_rise && i_idx_clr_en) begin
      pos_q <= '0;
    end else if (step_up) begin
      pos_q <= pos_q + K_CNT_W'(1);
    end else if (step_dn) begin
      pos_q <= pos_q - K_CNT_W'(1);
    end
  end

  // Direction of the most recent valid step.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      o_dir <= 1'b0;
    end else if (step_up) begin
      o_dir <= 1'b1;
    end else if (step_dn) begin
      o_dir <= 1'b0;
    end
  end

  // Sticky error and index flags.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      o_err        <= 1'b0;
      o_index_seen <= 1'b0;
    end else if (i_clr) begin
      o_err        <= 1'b0;
      o_index_seen <= 1'b0;
    end else begin
      if (step_bad) o_err <= 1'b1;
      if (idx_rise) o_index_seen <= 1'b1;
    end
  end

  // Measurement window: tick counter, accumulator and latched speed.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      tick_cnt      <= '0;
      acc_q         <= '0;
      speed_q       <= '0;
      o_speed_valid <= 1'b0;
    end else begin
      o_speed_valid <= win_end && !i_clr;
      if (i_clr) begin
        tick_cnt <= '0;
        acc_q    <= '0;
        speed_q  <= '0;
      end else if (!win_en) begin
        tick_cnt <= '0;
        acc_q    <= '0;
      end else if (win_end) begin
        speed_q  <= acc_sat;
        acc_q    <= '0;
        tick_cnt <= '0;
      end else begin
        acc_q <= acc_sat;
        if (i_tick) tick_cnt <= tick_cnt + K_WIN_W'(1);
      end
    end
  end

  // Consecutive zero-speed window counter and stall flag, updated with the speed.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      stall_cnt <= '0;
      o_stall   <= 1'b0;
    end else if (i_clr) begin
      stall_cnt <= '0;
      o_stall   <= 1'b0;
    end else if (win_end) begin
      stall_cnt <= stall_next;
      o_stall   <= (stall_next >= 8'(K_STALL_WIN));
    end
  end

  assign o_position = pos_q;
  assign o_speed    = speed_q;

endmodule
